// File: rtl/gpio_bus_arbiter.sv
// -----------------------------------------------------------------------------
// gpio_bus_arbiter
//   Round-robin arbiter and access sequencer in front of the GPIO_register
//   slave port. Each requester issues single read/write transactions; the
//   block grants one at a time, drives the slave bus for the access, captures
//   read data and returns a one-hot response to the owner. Illegal offsets
//   (misaligned, above MAX_ADDR, or a write to RO_ADDR) are answered with an
//   error response and never reach the bus.
//
// Ports
//   sysclk      in   1            system clock (rising edge)
//   sysrst      in   1            asynchronous active-low reset
//   req_valid   in   NUM_REQ      per-requester request, held until req_ready
//   req_we      in   NUM_REQ      1 = write, 0 = read
//   req_addr    in   32*NUM_REQ   flattened offsets, requester i at [32*i+:32]
//   req_wdata   in   32*NUM_REQ   flattened write data
//   req_ready   out  NUM_REQ      one-hot combinational accept pulse
//   rsp_valid   out  NUM_REQ      one-hot one-cycle response to the owner
//   rsp_err     out  1            response is an illegal-access error
//   rsp_rdata   out  32           read data (0 for writes and errors)
//   busy        out  1            sequencer not idle
//   gpio_we     out  1            slave write enable
//   gpio_addr   out  32           slave register offset
//   gpio_dat_i  out  32           slave write data
//   gpio_dat_o  in   32           slave read data
// -----------------------------------------------------------------------------
module gpio_bus_arbiter #(
    parameter int          NUM_REQ  = 2,
    parameter logic [31:0] MAX_ADDR = 32'h0000_0024,
    parameter logic [31:0] RO_ADDR  = 32'h0000_0000
) (
    input  logic                    sysclk,
    input  logic                    sysrst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ-1:0]      req_we,
    input  logic [32*NUM_REQ-1:0]   req_addr,
    input  logic [32*NUM_REQ-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic                    rsp_err,
    output logic [31:0]             rsp_rdata,
    output logic                    busy,
    output logic                    gpio_we,
    output logic [31:0]             gpio_addr,
    output logic [31:0]             gpio_dat_i,
    input  logic [31:0]             gpio_dat_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    // Requester indices are carried in 2 bits so up to four requesters fit.
    localparam int PTR_W = 2;

    // An offset is legal when word aligned, in range and not a write to RO_ADDR.
    function automatic logic addr_legal(input logic [31:0] addr, input logic we);
        return (addr[1:0] == 2'b00) && (addr <= MAX_ADDR) && !(we && (addr == RO_ADDR));
    endfunction

    state_t             state_r;
    state_t             state_nxt_s;
    logic [PTR_W-1:0]   ptr_r;
    logic [PTR_W-1:0]   owner_r;
    logic               we_r;
    logic               err_r;
    logic [31:0]        addr_r;
    logic [31:0]        wdata_r;

    // Requests padded out to four lanes so every index is a full 2-bit value.
    logic [3:0]         valid4_s;
    logic [3:0]         we4_s;
    logic [31:0]        addr4_s  [4];
    logic [31:0]        wdata4_s [4];

    logic               found_s;
    logic [PTR_W-1:0]   grant_idx_s;
    logic [2:0]         sum_s;
    logic [2:0]         cand_s;
    logic               hit_s;
    logic               accept_s;
    logic               sel_we_s;
    logic [31:0]        sel_addr_s;
    logic [31:0]        sel_wdata_s;
    logic               sel_legal_s;
    logic [3:0]         ready4_s;

    logic               in_idle_s;
    logic               txn_we_s;
    logic               txn_err_s;
    logic [31:0]        txn_addr_s;
    logic [31:0]        txn_wdata_s;
    logic [PTR_W-1:0]   txn_owner_s;
    logic [3:0]         owner4_s;

    logic               gpio_we_nxt_s;
    logic [31:0]        gpio_addr_nxt_s;
    logic [31:0]        gpio_dat_i_nxt_s;
    logic [NUM_REQ-1:0] rsp_valid_nxt_s;
    logic               rsp_err_nxt_s;
    logic [31:0]        rsp_rdata_nxt_s;
    logic               busy_nxt_s;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        if (gi < NUM_REQ) begin : g_used
            assign valid4_s[gi] = req_valid[gi];
            assign we4_s[gi]    = req_we[gi];
            assign addr4_s[gi]  = req_addr[32*gi +: 32];
            assign wdata4_s[gi] = req_wdata[32*gi +: 32];
        end else begin : g_unused
            assign valid4_s[gi] = 1'b0;
            assign we4_s[gi]    = 1'b0;
            assign addr4_s[gi]  = 32'h0000_0000;
            assign wdata4_s[gi] = 32'h0000_0000;
        end
    end

    // Round-robin search: first valid requester after the pointer, wrapping.
    always_comb begin
        found_s     = 1'b0;
        grant_idx_s = '0;
        sum_s       = 3'd0;
        cand_s      = 3'd0;
        hit_s       = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            sum_s       = {1'b0, ptr_r} + 3'(k);
            // ptr < NUM_REQ and k <= NUM_REQ, so one subtraction is a full modulo.
            cand_s      = (sum_s >= 3'(NUM_REQ)) ? (sum_s - 3'(NUM_REQ)) : sum_s;
            hit_s       = valid4_s[cand_s[1:0]] & ~found_s;
            grant_idx_s = hit_s ? cand_s[1:0] : grant_idx_s;
            found_s     = found_s | hit_s;
        end
    end

    // Selected request payload, accept decision and combinational ready pulse.
    always_comb begin
        in_idle_s   = (state_r == ST_IDLE);
        accept_s    = in_idle_s && found_s;
        sel_we_s    = we4_s[grant_idx_s];
        sel_addr_s  = addr4_s[grant_idx_s];
        sel_wdata_s = wdata4_s[grant_idx_s];
        sel_legal_s = addr_legal(sel_addr_s, sel_we_s);
        // Gated by reset so the port is quiet while the block is held in reset.
        ready4_s    = (accept_s && sysrst) ? (4'b0001 << grant_idx_s) : 4'b0000;
        req_ready   = ready4_s[NUM_REQ-1:0];
    end

    // Next-state logic of the access sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (found_s) begin
                    state_nxt_s = sel_legal_s ? ST_ACCESS : ST_RESP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACCESS:  state_nxt_s = we_r ? ST_RESP : ST_CAPTURE;
            ST_CAPTURE: state_nxt_s = ST_RESP;
            ST_RESP:    state_nxt_s = ST_IDLE;
            default:    state_nxt_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs, taken from the transaction being
    // accepted this cycle (IDLE) or from the latched one (all other states).
    always_comb begin
        txn_we_s         = in_idle_s ? sel_we_s : we_r;
        txn_err_s        = in_idle_s ? ~sel_legal_s : err_r;
        txn_addr_s       = in_idle_s ? sel_addr_s : addr_r;
        txn_wdata_s      = in_idle_s ? sel_wdata_s : wdata_r;
        txn_owner_s      = in_idle_s ? grant_idx_s : owner_r;
        owner4_s         = 4'b0001 << txn_owner_s;

        gpio_we_nxt_s    = (state_nxt_s == ST_ACCESS) ? txn_we_s : 1'b0;
        gpio_addr_nxt_s  = ((state_nxt_s == ST_ACCESS) || (state_nxt_s == ST_CAPTURE))
                           ? txn_addr_s : 32'h0000_0000;
        gpio_dat_i_nxt_s = ((state_nxt_s == ST_ACCESS) && txn_we_s)
                           ? txn_wdata_s : 32'h0000_0000;
        rsp_valid_nxt_s  = (state_nxt_s == ST_RESP) ? owner4_s[NUM_REQ-1:0] : '0;
        rsp_err_nxt_s    = (state_nxt_s == ST_RESP) ? txn_err_s : 1'b0;
        // Read data is sampled at the end of CAPTURE, on the way into RESP.
        rsp_rdata_nxt_s  = ((state_nxt_s == ST_RESP) && (state_r == ST_CAPTURE))
                           ? gpio_dat_o : 32'h0000_0000;
        busy_nxt_s       = (state_nxt_s != ST_IDLE);
    end

    // State register and registered outputs.
    always_ff @(posedge sysclk or negedge sysrst) begin
        if (!sysrst) begin
            state_r    <= ST_IDLE;
            gpio_we    <= 1'b0;
            gpio_addr  <= 32'h0000_0000;
            gpio_dat_i <= 32'h0000_0000;
            rsp_valid  <= '0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= 32'h0000_0000;
            busy       <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            gpio_we    <= gpio_we_nxt_s;
            gpio_addr  <= gpio_addr_nxt_s;
            gpio_dat_i <= gpio_dat_i_nxt_s;
            rsp_valid  <= rsp_valid_nxt_s;
            rsp_err    <= rsp_err_nxt_s;
            rsp_rdata  <= rsp_rdata_nxt_s;
            busy       <= busy_nxt_s;
        end
    end

    // Transaction latch and round-robin pointer, loaded on accept only.
    always_ff @(posedge sysclk or negedge sysrst) begin
        if (!sysrst) begin
            ptr_r   <= PTR_W'(NUM_REQ - 1);
            owner_r <= '0;
            we_r    <= 1'b0;
            err_r   <= 1'b0;
            addr_r  <= 32'h0000_0000;
            wdata_r <= 32'h0000_0000;
        end else if (accept_s) begin
            ptr_r   <= grant_idx_s;
            owner_r <= grant_idx_s;
            we_r    <= sel_we_s;
            err_r   <= ~sel_legal_s;
            addr_r  <= sel_addr_s;
            wdata_r <= sel_wdata_s;
        end else begin
            ptr_r   <= ptr_r;
            owner_r <= owner_r;
            we_r    <= we_r;
            err_r   <= err_r;
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
        end
    end

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_gpio_bus_arbiter
//   Bench for gpio_bus_arbiter with three requesters and a small behavioural
//   GPIO register slave. Expected outputs come from a latency table: every
//   accepted transaction schedules what the bus and response ports must show
//   in the following cycles; all unscheduled cycles must be idle (zero).
// -----------------------------------------------------------------------------
module tb_gpio_bus_arbiter;

    localparam int NR    = 3;
    localparam int DEPTH = 4096;

    logic              sysclk = 1'b0;
    logic              sysrst = 1'b1;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_we = '0;
    logic [32*NR-1:0]  req_addr = '0;
    logic [32*NR-1:0]  req_wdata = '0;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     rsp_valid;
    logic              rsp_err;
    logic [31:0]       rsp_rdata;
    logic              busy;
    logic              gpio_we;
    logic [31:0]       gpio_addr;
    logic [31:0]       gpio_dat_i;
    logic [31:0]       gpio_dat_o;

    always #5 sysclk = ~sysclk;

    gpio_bus_arbiter #(.NUM_REQ(NR)) dut (
        .sysclk     (sysclk),
        .sysrst     (sysrst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_err    (rsp_err),
        .rsp_rdata  (rsp_rdata),
        .busy       (busy),
        .gpio_we    (gpio_we),
        .gpio_addr  (gpio_addr),
        .gpio_dat_i (gpio_dat_i),
        .gpio_dat_o (gpio_dat_o)
    );

    // ---------------- GPIO register slave ----------------
    logic [15:0][31:0] gmem = '0;
    logic [31:0]       in_pad = 32'h0;

    // Offset 0 reads the pads, INTS (0x1C) is pads & INTE & PTRIG.
    function automatic logic [31:0] slave_read(input logic [31:0] a,
                                               input logic [15:0][31:0] m,
                                               input logic [31:0] pad);
        if (a == 32'h0)       return pad;
        else if (a == 32'h1C) return pad & m[3] & m[4];
        else if (a <= 32'h3C) return m[a[5:2]];
        else                  return 32'h0;
    endfunction

    assign gpio_dat_o = slave_read(gpio_addr, gmem, in_pad);

    always @(posedge sysclk) begin
        if (gpio_we && (gpio_addr <= 32'h3C)) gmem[gpio_addr[5:2]] <= gpio_dat_i;
    end

    // ---------------- model state ----------------
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    txn_t        q [NR][$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          free_at  = 0;
    int          m_ptr    = NR - 1;
    int          drop_pct = 0;

    logic        e_we    [DEPTH];
    logic [31:0] e_addr  [DEPTH];
    logic [31:0] e_dat   [DEPTH];
    logic [NR-1:0] e_rv  [DEPTH];
    logic        e_err   [DEPTH];
    logic [31:0] e_rdata [DEPTH];
    logic        e_busy  [DEPTH];

    int          o_rdy_cyc, o_we_cnt, o_we_cyc, o_rsp_cyc;
    logic [31:0] o_we_addr, o_rdata;
    logic        o_err;
    logic [NR-1:0] o_rv;
    int          grant_log[$];
    int          rsp_log[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
        end
    endtask

    function automatic int onehot_idx(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            e_we[i] = 1'b0; e_addr[i] = 32'h0; e_dat[i] = 32'h0; e_rv[i] = '0;
            e_err[i] = 1'b0; e_rdata[i] = 32'h0; e_busy[i] = 1'b0;
        end
        cyc = 0; free_at = 0; m_ptr = NR - 1;
    endtask

    task automatic obs_clear();
        o_rdy_cyc = -100; o_we_cnt = 0; o_we_cyc = -100; o_rsp_cyc = -100;
        o_we_addr = 32'h0; o_rdata = 32'h0; o_err = 1'b0; o_rv = '0;
        grant_log.delete(); rsp_log.delete();
    endtask

    task automatic push(input int i, input logic we, input logic [31:0] a, input logic [31:0] d);
        txn_t t;
        t.we = we; t.addr = a; t.wdata = d;
        q[i].push_back(t);
    endtask

    task automatic put_rsp(input int c, input int g, input logic err, input logic [31:0] rd);
        e_rv[c]    = NR'(1) << g;
        e_err[c]   = err;
        e_rdata[c] = rd;
        e_busy[c]  = 1'b1;
    endtask

    // One clock cycle: check registered outputs, drive requests, check ready,
    // and let the model accept and schedule the transaction's timeline.
    task automatic step();
        logic [NR-1:0] v;
        int            g;
        logic          legal;
        txn_t          t;
        @(negedge sysclk);
        if (cyc >= DEPTH - 8) begin
            $display("FAIL cycle_budget cyc=%0d", cyc);
            $fatal(1);
        end
        chk("gpio_we",    32'(gpio_we),    32'(e_we[cyc]));
        chk("gpio_addr",  gpio_addr,       e_addr[cyc]);
        chk("gpio_dat_i", gpio_dat_i,      e_dat[cyc]);
        chk("rsp_valid",  32'(rsp_valid),  32'(e_rv[cyc]));
        chk("rsp_err",    32'(rsp_err),    32'(e_err[cyc]));
        chk("rsp_rdata",  rsp_rdata,       e_rdata[cyc]);
        chk("busy",       32'(busy),       32'(e_busy[cyc]));
        if (gpio_we) begin
            o_we_cnt++; o_we_cyc = cyc; o_we_addr = gpio_addr;
        end
        if (rsp_valid != '0) begin
            o_rsp_cyc = cyc; o_rv = rsp_valid; o_err = rsp_err; o_rdata = rsp_rdata;
            rsp_log.push_back(onehot_idx(rsp_valid));
        end
        for (int i = 0; i < NR; i++) begin
            if (q[i].size() > 0) begin
                t = q[i][0];
                req_valid[i]          = ($urandom_range(99) >= drop_pct);
                req_we[i]             = t.we;
                req_addr[32*i +: 32]  = t.addr;
                req_wdata[32*i +: 32] = t.wdata;
            end else begin
                req_valid[i]          = 1'b0;
                req_we[i]             = 1'($urandom);
                req_addr[32*i +: 32]  = $urandom;
                req_wdata[32*i +: 32] = $urandom;
            end
        end
        #1;
        v = req_valid;
        g = -1;
        if (cyc >= free_at) begin
            for (int k = 1; k <= NR; k++) begin
                int c;
                c = (m_ptr + k) % NR;
                if (g < 0 && v[c]) g = c;
            end
        end
        chk("req_ready", 32'(req_ready), (g >= 0) ? (32'h1 << g) : 32'h0);
        if (req_ready != '0) begin
            o_rdy_cyc = cyc;
            grant_log.push_back(onehot_idx(req_ready));
        end
        if (g >= 0) begin
            t     = q[g].pop_front();
            m_ptr = g;
            legal = (t.addr[1:0] == 2'b00) && (t.addr <= 32'h24) && !(t.we && t.addr == 32'h0);
            if (!legal) begin
                put_rsp(cyc + 1, g, 1'b1, 32'h0);
                free_at = cyc + 2;
            end else if (t.we) begin
                e_we[cyc+1] = 1'b1; e_addr[cyc+1] = t.addr; e_dat[cyc+1] = t.wdata;
                e_busy[cyc+1] = 1'b1;
                put_rsp(cyc + 2, g, 1'b0, 32'h0);
                free_at = cyc + 3;
            end else begin
                e_addr[cyc+1] = t.addr; e_busy[cyc+1] = 1'b1;
                e_addr[cyc+2] = t.addr; e_busy[cyc+2] = 1'b1;
                put_rsp(cyc + 3, g, 1'b0, slave_read(t.addr, gmem, in_pad));
                free_at = cyc + 4;
            end
        end
        cyc++;
    endtask

    task automatic run_until_idle();
        int guard;
        guard = 0;
        while (((q[0].size() + q[1].size() + q[2].size()) > 0 || cyc < free_at) && guard < 400) begin
            step();
            guard++;
        end
        chk("drain_timeout", 32'(guard >= 400), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        // ---- reset state ----
        model_clear();
        obs_clear();
        #2 sysrst = 1'b0;
        #1;
        chk("rst_busy",      32'(busy),      32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_gpio_addr", gpio_addr,      32'h0);
        repeat (3) @(negedge sysclk);
        sysrst = 1'b1;

        // ---- 1: reset in the middle of a read (CAPTURE) ----
        push(0, 1'b0, 32'h08, 32'h0);
        repeat (3) step();
        #1 sysrst = 1'b0;
        req_valid = '1;
        #1;
        chk("rst_mid_busy",      32'(busy),       32'h0);
        chk("rst_mid_gpio_addr", gpio_addr,       32'h0);
        chk("rst_mid_gpio_we",   32'(gpio_we),    32'h0);
        chk("rst_mid_dat_i",     gpio_dat_i,      32'h0);
        chk("rst_mid_rsp_valid", 32'(rsp_valid),  32'h0);
        chk("rst_mid_rsp_err",   32'(rsp_err),    32'h0);
        chk("rst_mid_rdata",     rsp_rdata,       32'h0);
        chk("rst_mid_ready",     32'(req_ready),  32'h0);
        repeat (2) @(negedge sysclk);
        req_valid = '0;
        model_clear();
        obs_clear();
        sysrst = 1'b1;
        push(0, 1'b0, 32'h04, 32'h0);
        push(1, 1'b0, 32'h08, 32'h0);
        run_until_idle();
        chk("rst_first_grant",  32'(grant_log.size() > 0 ? grant_log[0] : -1), 32'h0);
        chk("rst_rsp_count",    32'(rsp_log.size()), 32'd2);

        // ---- 2: single write ----
        obs_clear();
        push(0, 1'b1, 32'h04, 32'hA5A5A5A5);
        run_until_idle();
        chk("wr_we_count",   32'(o_we_cnt),              32'd1);
        chk("wr_we_cycle",   32'(o_we_cyc - o_rdy_cyc),  32'd1);
        chk("wr_we_addr",    o_we_addr,                  32'h04);
        chk("wr_rsp_cycle",  32'(o_rsp_cyc - o_rdy_cyc), 32'd2);
        chk("wr_rsp_owner",  32'(o_rv),                  32'h1);
        chk("wr_rsp_err",    32'(o_err),                 32'h0);
        chk("wr_slave_data", gmem[1],                    32'hA5A5A5A5);

        // ---- 3: read of RGPIO_IN by requester 1 ----
        push(0, 1'b1, 32'h08, 32'hFFFFFFFF);
        run_until_idle();
        in_pad = 32'h12345678;
        obs_clear();
        push(1, 1'b0, 32'h00, 32'h0);
        run_until_idle();
        chk("rd_rsp_cycle", 32'(o_rsp_cyc - o_rdy_cyc), 32'd3);
        chk("rd_rsp_owner", 32'(o_rv),                  32'h2);
        chk("rd_rdata",     o_rdata,                    32'h12345678);
        chk("rd_err",       32'(o_err),                 32'h0);

        // ---- 4: fairness with three requesters held valid ----
        push(2, 1'b0, 32'h08, 32'h0);
        run_until_idle();
        obs_clear();
        for (int j = 0; j < 3; j++) begin
            for (int i = 0; i < NR; i++) begin
                push(i, 1'($urandom), 32'(4 * $urandom_range(5, 9)), $urandom);
            end
        end
        run_until_idle();
        chk("fair_grants", 32'(grant_log.size()), 32'd9);
        chk("fair_rsps",   32'(rsp_log.size()),   32'd9);
        for (int k = 0; k < 9; k++) begin
            if (k < grant_log.size()) chk("fair_order", 32'(grant_log[k]), 32'(k % 3));
            if (k < rsp_log.size())   chk("fair_owner", 32'(rsp_log[k]),   32'(k % 3));
        end

        // ---- 5: illegal accesses ----
        for (int e = 0; e < 3; e++) begin
            obs_clear();
            case (e)
                0:       push(0, 1'b1, 32'h00, 32'hDEADBEEF);
                1:       push(0, 1'b0, 32'h06, 32'h0);
                default: push(0, 1'b0, 32'h28, 32'h0);
            endcase
            run_until_idle();
            chk("err_rsp_cycle", 32'(o_rsp_cyc - o_rdy_cyc), 32'd1);
            chk("err_flag",      32'(o_err),                 32'h1);
            chk("err_rdata",     o_rdata,                    32'h0);
            chk("err_no_we",     32'(o_we_cnt),              32'd0);
        end

        // ---- 6: interrupt status flow ----
        push(0, 1'b1, 32'h0C, 32'hFF);
        push(0, 1'b1, 32'h10, 32'hFF);
        run_until_idle();
        in_pad = 32'hF0;
        obs_clear();
        push(0, 1'b0, 32'h1C, 32'h0);
        run_until_idle();
        chk("ints_bits", 32'(o_rdata[7:4]), 32'hF);

        // ---- randomized traffic with occasional dropped requests ----
        in_pad   = $urandom;
        drop_pct = 10;
        for (int n = 0; n < 500; n++) begin
            for (int i = 0; i < NR; i++) begin
                if (q[i].size() == 0 && $urandom_range(3) == 0) begin
                    int pick;
                    logic [31:0] a;
                    pick = $urandom_range(0, 15);
                    if (pick <= 10)      a = 32'(4 * pick);
                    else if (pick <= 12) a = 32'($urandom_range(0, 36)) | 32'h1;
                    else                 a = 32'h40 + 32'(4 * $urandom_range(0, 63));
                    push(i, 1'($urandom), a, $urandom);
                end
            end
            step();
        end
        drop_pct = 0;
        run_until_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
